// File: rtl/mp64_bus_rr_pkg.sv
// Shared constants and types for the MP64 bus arbiter: MMIO window, error data,
// arbiter state encoding and a width helper.
package mp64_bus_rr_pkg;

   localparam logic [31:0] MMIO_HI      = 32'h0000_F000;
   localparam logic [63:0] BUS_ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_MEM_WAIT  = 2'd1,
      ST_MMIO_WAIT = 2'd2
   } arb_state_e;

   // Request fields that stay stable while a target transaction is pending
   typedef struct packed {
      logic        req;
      logic [63:0] wdata;
      logic        wen;
      logic [1:0]  size;
   } tgt_req_t;

   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mp64_rr_pick.sv
// Rotating-priority picker: first requester after i_last, wrapping modulo N with
// an explicit compare so any N works. i_excl skips i_last itself.
module mp64_rr_pick
   import mp64_bus_rr_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_last,
   input  logic         i_excl,
   output logic [W-1:0] o_idx,
   output logic         o_any
);

   int w_cand;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      o_idx  = i_last;
      o_any  = 1'b0;
      w_cand = 0;
      for (int k = 1; k <= N; k++) begin
         w_cand = int'(i_last) + k;
         if (w_cand >= N) w_cand = w_cand - N;
         if (!o_any && i_req[W'(w_cand)] && !(i_excl && (w_cand == int'(i_last)))) begin
            o_any = 1'b1;
            o_idx = W'(w_cand);
         end
      end
   end

endmodule

// File: rtl/mp64_bus_rr.sv
// NCORES-master round-robin arbiter and address decoder for the MP64 fabric:
// routes one transaction at a time to memory or MMIO, with timeout and bounded lock.
module mp64_bus_rr
   import mp64_bus_rr_pkg::*;
#(
   parameter int          NCORES       = 4,
   parameter logic [31:0] MMIO_HI_VAL  = MMIO_HI,
   parameter int          MMIO_TIMEOUT = 255,
   parameter int          MEM_TIMEOUT  = 1023,
   parameter int          LOCK_MAX     = 4,
   localparam int         GRANT_W      = width_of(NCORES)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NCORES-1:0]      cpu_valid,
   input  logic [NCORES*64-1:0]   cpu_addr,
   input  logic [NCORES*64-1:0]   cpu_wdata,
   input  logic [NCORES-1:0]      cpu_wen,
   input  logic [NCORES*2-1:0]    cpu_size,
   input  logic [NCORES-1:0]      cpu_lock,
   output logic [NCORES*64-1:0]   cpu_rdata,
   output logic [NCORES-1:0]      cpu_ready,
   output logic [NCORES-1:0]      cpu_err,
   output logic                   mem_req,
   output logic [63:0]            mem_addr,
   output logic [63:0]            mem_wdata,
   output logic                   mem_wen,
   output logic [1:0]             mem_size,
   input  logic [63:0]            mem_rdata,
   input  logic                   mem_ack,
   output logic                   mmio_req,
   output logic [11:0]            mmio_addr,
   output logic [63:0]            mmio_wdata,
   output logic                   mmio_wen,
   output logic [1:0]             mmio_size,
   input  logic [63:0]            mmio_rdata,
   input  logic                   mmio_ack,
   output logic [GRANT_W-1:0]     grant_id
);

   localparam int TMAX  = (MEM_TIMEOUT > MMIO_TIMEOUT) ? MEM_TIMEOUT : MMIO_TIMEOUT;
   localparam int TMR_W = width_of(TMAX + 1);
   localparam int LCK_W = width_of(LOCK_MAX + 1);

   arb_state_e                r_state, w_state_nxt;
   logic [GRANT_W-1:0]        r_last, r_grant_id, w_pick_idx, w_grant_idx;
   logic                      r_locked_hold, r_served_last;
   logic [LCK_W-1:0]          r_lock_cnt;
   logic [TMR_W-1:0]          r_timer;
   tgt_req_t                  r_mem, r_mmio;
   logic [63:0]               r_mem_addr;
   logic [11:0]               r_mmio_addr;
   logic [NCORES-1:0]         r_ready, r_err;
   logic [NCORES-1:0][63:0]   r_rdata;
   logic                      w_pick_any, w_use_hold, w_grant_ok, w_sel_mmio;
   logic                      w_done, w_err, w_mem_to, w_mmio_to;
   logic [63:0]               w_sel_addr, w_sel_wdata, w_tgt_rdata;
   logic [1:0]                w_sel_size;

   mp64_rr_pick #(.N(NCORES), .W(GRANT_W)) u_pick (
      .i_req  (cpu_valid),
      .i_last (r_last),
      .i_excl (r_served_last),
      .o_idx  (w_pick_idx),
      .o_any  (w_pick_any)
   );

   // A locked core keeps the bus only while it is still asking for it
   assign w_use_hold  = r_locked_hold && cpu_valid[r_last];
   assign w_grant_ok  = w_use_hold || w_pick_any;
   assign w_grant_idx = w_use_hold ? r_last : w_pick_idx;
   assign w_sel_addr  = cpu_addr[int'(w_grant_idx)*64 +: 64];
   assign w_sel_wdata = cpu_wdata[int'(w_grant_idx)*64 +: 64];
   assign w_sel_size  = cpu_size[int'(w_grant_idx)*2 +: 2];
   assign w_sel_mmio  = (w_sel_addr[63:32] == MMIO_HI_VAL);

   assign w_mem_to  = (MEM_TIMEOUT != 0)  && (r_timer == TMR_W'(MEM_TIMEOUT - 1));
   assign w_mmio_to = (MMIO_TIMEOUT != 0) && (r_timer == TMR_W'(MMIO_TIMEOUT - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      w_err       = 1'b0;
      w_tgt_rdata = mem_rdata;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_ok) w_state_nxt = w_sel_mmio ? ST_MMIO_WAIT : ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            if (mem_ack)       w_done = 1'b1;
            else if (w_mem_to) begin w_done = 1'b1; w_err = 1'b1; end
         end
         ST_MMIO_WAIT: begin
            w_tgt_rdata = mmio_rdata;
            if (mmio_ack)       w_done = 1'b1;
            else if (w_mmio_to) begin w_done = 1'b1; w_err = 1'b1; end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_done) w_state_nxt = ST_IDLE;
      if (w_err)  w_tgt_rdata = BUS_ERR_DATA;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_last        <= GRANT_W'(NCORES - 1);
         r_grant_id    <= '0;
         r_locked_hold <= 1'b0;
         r_served_last <= 1'b0;
         r_lock_cnt    <= '0;
         r_timer       <= '0;
         r_mem         <= '0;
         r_mmio        <= '0;
         r_mem_addr    <= '0;
         r_mmio_addr   <= '0;
         r_ready       <= '0;
         r_err         <= '0;
         r_rdata       <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= '0;
         r_err   <= '0;
         if (r_state == ST_IDLE) begin
            if (w_grant_ok) begin
               r_grant_id <= w_grant_idx;
               r_timer    <= '0;
               if (w_sel_mmio) begin
                  r_mmio      <= '{req: 1'b1, wdata: w_sel_wdata, wen: cpu_wen[w_grant_idx], size: w_sel_size};
                  r_mmio_addr <= w_sel_addr[11:0];
               end else begin
                  r_mem      <= '{req: 1'b1, wdata: w_sel_wdata, wen: cpu_wen[w_grant_idx], size: w_sel_size};
                  r_mem_addr <= w_sel_addr;
               end
            end else begin
               r_served_last <= 1'b0;
            end
            if (r_locked_hold && !cpu_valid[r_last]) begin
               r_locked_hold <= 1'b0;
               r_lock_cnt    <= '0;
            end
         end else begin
            r_timer <= r_timer + 1'b1;
            if (w_done) begin
               r_mem.req              <= 1'b0;
               r_mmio.req             <= 1'b0;
               r_ready[r_grant_id]    <= 1'b1;
               r_err[r_grant_id]      <= w_err;
               r_rdata[r_grant_id]    <= w_tgt_rdata;
               r_last                 <= r_grant_id;
               if (cpu_lock[r_grant_id] && (r_lock_cnt < LCK_W'(LOCK_MAX - 1))) begin
                  r_locked_hold <= 1'b1;
                  r_lock_cnt    <= r_lock_cnt + 1'b1;
                  r_served_last <= 1'b0;
               end else begin
                  r_locked_hold <= 1'b0;
                  r_lock_cnt    <= '0;
                  r_served_last <= 1'b1;
               end
            end
         end
      end
   end

   assign cpu_rdata  = r_rdata;
   assign cpu_ready  = r_ready;
   assign cpu_err    = r_err;
   assign mem_req    = r_mem.req;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem.wdata;
   assign mem_wen    = r_mem.wen;
   assign mem_size   = r_mem.size;
   assign mmio_req   = r_mmio.req;
   assign mmio_addr  = r_mmio_addr;
   assign mmio_wdata = r_mmio.wdata;
   assign mmio_wen   = r_mmio.wen;
   assign mmio_size  = r_mmio.size;
   assign grant_id   = r_grant_id;

endmodule

// File: tb/tb_mp64_bus_rr.sv
// Scoreboard bench for mp64_bus_rr: a 4-core instance with short timeouts and a
// 3-core instance for non-power-of-two rotation.
module tb_mp64_bus_rr;
   import mp64_bus_rr_pkg::*;

   typedef struct {
      int          core;
      logic [63:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 4-core instance
   logic [3:0]   cpu_valid, cpu_wen, cpu_lock, cpu_ready, cpu_err;
   logic [255:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic [7:0]   cpu_size;
   logic         mem_req, mem_wen, mem_ack, mmio_req, mmio_wen, mmio_ack;
   logic [63:0]  mem_addr, mem_wdata, mem_rdata, mmio_wdata, mmio_rdata;
   logic [1:0]   mem_size, mmio_size, grant_id;
   logic [11:0]  mmio_addr;

   mp64_bus_rr #(.NCORES(4), .MMIO_TIMEOUT(8), .MEM_TIMEOUT(16), .LOCK_MAX(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wen(cpu_wen),
      .cpu_size(cpu_size), .cpu_lock(cpu_lock), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .cpu_err(cpu_err),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
      .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .mmio_req(mmio_req), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_wen(mmio_wen),
      .mmio_size(mmio_size), .mmio_rdata(mmio_rdata), .mmio_ack(mmio_ack),
      .grant_id(grant_id)
   );

   // 3-core instance
   logic [2:0]   v3, wen3, lock3, ready3, err3;
   logic [191:0] addr3, wdata3, rdata3;
   logic [5:0]   size3;
   logic         mem_req3, mem_wen3, mem_ack3, mmio_req3, mmio_wen3, mmio_ack3;
   logic [63:0]  mem_addr3, mem_wdata3, mem_rdata3, mmio_wdata3, mmio_rdata3;
   logic [1:0]   mem_size3, mmio_size3, gid3;
   logic [11:0]  mmio_addr3;

   mp64_bus_rr #(.NCORES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .cpu_valid(v3), .cpu_addr(addr3), .cpu_wdata(wdata3), .cpu_wen(wen3),
      .cpu_size(size3), .cpu_lock(lock3), .cpu_rdata(rdata3), .cpu_ready(ready3),
      .cpu_err(err3),
      .mem_req(mem_req3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_wen(mem_wen3),
      .mem_size(mem_size3), .mem_rdata(mem_rdata3), .mem_ack(mem_ack3),
      .mmio_req(mmio_req3), .mmio_addr(mmio_addr3), .mmio_wdata(mmio_wdata3), .mmio_wen(mmio_wen3),
      .mmio_size(mmio_size3), .mmio_rdata(mmio_rdata3), .mmio_ack(mmio_ack3),
      .grant_id(gid3)
   );

   int          n_total = 0;
   int          n_bad   = 0;
   exp_t        sb[$];
   exp_t        sb3[$];
   logic [63:0] a_addr[4];
   int          rem[4];
   logic        lk[4];
   logic [63:0] a3[3];
   int          rem3[3];
   int          cyc = 0, t_req = 0, mem_dly = 1, mcnt = 0, io_dly = 0, icnt = 0;
   logic        io_never = 1'b0, prev_req = 1'b0;
   logic [63:0] io_data = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] mem_f(input logic [63:0] a);
      return a ^ 64'h5A5A_0F0F_C3C3_9696;
   endfunction

   task automatic push(input int core, input logic [63:0] rd, input logic er, input int lat);
      exp_t e;
      e.core = core; e.rdata = rd; e.err = er; e.lat = lat;
      sb.push_back(e);
   endtask

   task automatic apply();
      for (int i = 0; i < 4; i++) begin
         cpu_valid[i]         = (rem[i] > 0);
         cpu_lock[i]          = lk[i] && (rem[i] > 0);
         cpu_addr[i*64 +: 64] = a_addr[i];
         cpu_wdata[i*64 +: 64] = {32'hD0D0_0000, 32'(i)};
      end
      cpu_wen  = '0;
      cpu_size = '1;
   endtask

   task automatic apply3();
      for (int i = 0; i < 3; i++) begin
         v3[i]              = (rem3[i] > 0);
         addr3[i*64 +: 64]  = a3[i];
         wdata3[i*64 +: 64] = 64'(i);
      end
      wen3 = '0; lock3 = '0; size3 = '0;
   endtask

   // One cycle of the 4-core environment: observe outputs, score completions, respond.
   task automatic step();
      exp_t e;
      logic rq;
      @(negedge clk);
      cyc++;
      rq = mem_req | mmio_req;
      if (rq && !prev_req) begin
         t_req = cyc;
         if (sb.size() > 0) begin
            check("grant_id", 64'(grant_id), 64'(sb[0].core));
            if (mem_req) check("mem_addr", mem_addr, a_addr[sb[0].core]);
            else         check("mmio_addr", 64'(mmio_addr), 64'(a_addr[sb[0].core][11:0]));
         end
      end
      prev_req = rq;
      for (int i = 0; i < 4; i++) begin
         if (cpu_ready[i]) begin
            if (sb.size() == 0) begin
               check("extra_ready", 64'(sb.size()), 64'd1);
            end else begin
               e = sb.pop_front();
               check("ready_core", 64'(i), 64'(e.core));
               check("rdata", cpu_rdata[i*64 +: 64], e.rdata);
               check("err", 64'(cpu_err[i]), 64'(e.err));
               check("latency", 64'(cyc - t_req), 64'(e.lat));
            end
            rem[i]--;
            a_addr[i] = a_addr[i] + 64'd8;
            if (rem[i] <= 0) lk[i] = 1'b0;
         end
      end
      if (mem_ack) begin
         mem_ack = 1'b0;
      end else if (mem_req) begin
         if (mcnt >= mem_dly) begin mem_ack = 1'b1; mem_rdata = mem_f(mem_addr); mcnt = 0; end
         else mcnt++;
      end
      if (mmio_ack) begin
         mmio_ack = 1'b0;
      end else if (mmio_req && !io_never) begin
         if (icnt >= io_dly) begin mmio_ack = 1'b1; mmio_rdata = io_data; icnt = 0; end
         else icnt++;
      end
      apply();
   endtask

   task automatic run(input int budget);
      for (int n = 0; n < budget && sb.size() > 0; n++) step();
      if (sb.size() != 0) check("drain", 64'(sb.size()), 64'd0);
      for (int n = 0; n < 3; n++) step();
   endtask

   task automatic wait_req(input int budget);
      for (int n = 0; n < budget && !(mem_req || mmio_req); n++) step();
      check("req_seen", 64'(mem_req || mmio_req), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      exp_t e3;
      int   gmax3;
      for (int i = 0; i < 4; i++) begin rem[i] = 0; lk[i] = 1'b0; a_addr[i] = '0; end
      for (int i = 0; i < 3; i++) begin rem3[i] = 0; a3[i] = '0; end
      mem_ack = 1'b0; mem_rdata = '0; mmio_ack = 1'b0; mmio_rdata = '0;
      mem_ack3 = 1'b0; mem_rdata3 = '0; mmio_ack3 = 1'b0; mmio_rdata3 = '0;
      apply(); apply3();
      repeat (3) @(negedge clk);
      check("rst_mem_req", 64'(mem_req), 64'd0);
      check("rst_mmio_req", 64'(mmio_req), 64'd0);
      check("rst_ready", 64'(cpu_ready), 64'd0);
      check("rst_err", 64'(cpu_err), 64'd0);
      check("rst_grant_id", 64'(grant_id), 64'd0);
      check("rst_rdata", 64'(|cpu_rdata), 64'd0);
      check("rst_mem_addr", mem_addr, 64'd0);

      // Round robin across four memory requesters: 0,1,2,3,0
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) a_addr[i] = 64'h0000_0001_0000_0000 + 64'(i * 256);
      rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
      mem_dly = 1;
      push(0, mem_f(a_addr[0]), 1'b0, 2);
      push(1, mem_f(a_addr[1]), 1'b0, 2);
      push(2, mem_f(a_addr[2]), 1'b0, 2);
      push(3, mem_f(a_addr[3]), 1'b0, 2);
      push(0, mem_f(a_addr[0] + 64'd8), 1'b0, 2);
      apply();
      run(200);

      // MMIO read from core 2, ack three cycles after req
      a_addr[2] = {MMIO_HI, 32'h0000_0010};
      rem[2] = 1; io_dly = 3; io_data = 64'h1234;
      push(2, 64'h1234, 1'b0, 4);
      apply();
      run(100);

      // MMIO timeout, then a stray ack while idle
      a_addr[0] = {MMIO_HI, 32'h0000_0080};
      rem[0] = 1; io_never = 1'b1;
      push(0, BUS_ERR_DATA, 1'b1, 8);
      apply();
      run(100);
      io_never = 1'b0;
      mmio_ack = 1'b1; mmio_rdata = 64'hDEAD;
      for (int n = 0; n < 5; n++) step();
      check("stray_ready", 64'(cpu_ready), 64'd0);
      check("stray_mmio_req", 64'(mmio_req), 64'd0);
      check("stray_mem_req", 64'(mem_req), 64'd0);
      check("rdata_hold_c2", cpu_rdata[2*64 +: 64], 64'h1234);

      // Core 1 locked for LOCK_MAX grants, then 3, then 0
      mem_dly = 0;
      a_addr[1] = 64'h0000_0002_0000_1000;
      rem[1] = 4; lk[1] = 1'b1;
      for (int k = 0; k < 4; k++) push(1, mem_f(a_addr[1] + 64'(8 * k)), 1'b0, 1);
      apply();
      wait_req(10);
      a_addr[0] = 64'h0000_0002_0000_0000;
      a_addr[3] = 64'h0000_0002_0000_3000;
      rem[0] = 1; rem[3] = 1;
      push(3, mem_f(a_addr[3]), 1'b0, 1);
      push(0, mem_f(a_addr[0]), 1'b0, 1);
      apply();
      run(200);

      // Reset during MEM_WAIT: nothing replayed, core 0 first afterwards
      mem_dly = 10;
      a_addr[2] = 64'h0000_0003_0000_2000;
      rem[2] = 1;
      apply();
      wait_req(10);
      step(); step();
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_mem_req", 64'(mem_req), 64'd0);
      check("rst_async_ready", 64'(cpu_ready), 64'd0);
      check("rst_async_gid", 64'(grant_id), 64'd0);
      mem_ack = 1'b0; mcnt = 0; mem_dly = 1;
      a_addr[0] = 64'h0000_0003_0000_0000;
      rem[0] = 1;
      push(0, mem_f(a_addr[0]), 1'b0, 2);
      push(2, mem_f(a_addr[2]), 1'b0, 2);
      @(negedge clk);
      rst_n = 1'b1;
      prev_req = 1'b0;
      apply();
      run(200);

      // Three-core instance, cores 0 and 2 valid: 0,2,0,2
      a3[0] = 64'h0000_0004_0000_0000;
      a3[2] = 64'h0000_0004_0000_2000;
      rem3[0] = 2; rem3[2] = 2;
      for (int k = 0; k < 2; k++) begin
         e3.core = 0; e3.rdata = mem_f(a3[0] + 64'(8 * k)); e3.err = 1'b0; e3.lat = 0; sb3.push_back(e3);
         e3.core = 2; e3.rdata = mem_f(a3[2] + 64'(8 * k)); sb3.push_back(e3);
      end
      gmax3 = 0;
      apply3();
      for (int n = 0; n < 100 && sb3.size() > 0; n++) begin
         @(negedge clk);
         if (int'(gid3) > gmax3) gmax3 = int'(gid3);
         for (int i = 0; i < 3; i++) begin
            if (ready3[i]) begin
               if (sb3.size() == 0) begin
                  check("n3_extra_ready", 64'(sb3.size()), 64'd1);
               end else begin
                  e3 = sb3.pop_front();
                  check("n3_core", 64'(i), 64'(e3.core));
                  check("n3_gid", 64'(gid3), 64'(e3.core));
                  check("n3_rdata", rdata3[i*64 +: 64], e3.rdata);
               end
               rem3[i]--;
               a3[i] = a3[i] + 64'd8;
            end
         end
         if (mem_ack3) mem_ack3 = 1'b0;
         else if (mem_req3) begin mem_ack3 = 1'b1; mem_rdata3 = mem_f(mem_addr3); end
         apply3();
      end
      check("n3_drain", 64'(sb3.size()), 64'd0);
      check("n3_gid_range", 64'(gmax3 > 2), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
